// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: bridges the MEM-stage data port to a 32-bit asynchronous SRAM.
// Optional feature macro: SRAM_LAST_WORD_BUF_EN (one-word load-hit buffer).
`default_nettype none

`ifndef MEM_NOP
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LBU 4'd2
`define MEM_LH  4'd3
`define MEM_LHU 4'd4
`define MEM_LW  4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

module sram_mem_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ramOp_i,
  input  logic [31:0] ramAddr_i,
  input  logic [31:0] storeData_i,
  output logic [31:0] load_data_o,
  output logic        stall_o,
  output logic [19:0] sram_addr_o,
  input  logic [31:0] sram_data_i,
  output logic [31:0] sram_data_o,
  output logic        sram_data_oe_o,
  output logic [3:0]  sram_be_n_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WSETUP = 3'd2,
    S_WPULSE = 3'd3,
    S_WHOLD  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] load_data_q, load_data_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_n_q, be_n_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        data_oe_q, data_oe_d;

  logic        in_load, in_store, accept, hit, active_d, load_done;
  logic [3:0]  be_new, src_op;
  logic [1:0]  src_lo;
  logic [31:0] wdata_new, src_word;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^ramAddr_i[31:22];

  function automatic logic is_load(input logic [3:0] op);
    return (op == `MEM_LB) || (op == `MEM_LBU) || (op == `MEM_LH) ||
           (op == `MEM_LHU) || (op == `MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == `MEM_SB) || (op == `MEM_SH) || (op == `MEM_SW);
  endfunction

  function automatic logic [31:0] extract(input logic [3:0] op, input logic [1:0] lo,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      `MEM_LB:  extract = {{24{b[7]}}, b};
      `MEM_LBU: extract = {24'h0, b};
      `MEM_LH:  extract = {{16{h[15]}}, h};
      `MEM_LHU: extract = {16'h0, h};
      default:  extract = w;
    endcase
  endfunction

  assign in_load  = is_load(ramOp_i);
  assign in_store = is_store(ramOp_i);
  assign accept   = (state_q == S_IDLE) && (in_load || in_store);

  // Lane placement: narrow stores are replicated so the byte enables alone pick the lane.
  always_comb begin
    wdata_new = storeData_i;
    be_new    = 4'b0000;
    case (ramOp_i)
      `MEM_SB: begin
        wdata_new = {4{storeData_i[7:0]}};
        be_new    = ~(4'b0001 << ramAddr_i[1:0]);
      end
      `MEM_SH: begin
        wdata_new = {2{storeData_i[15:0]}};
        be_new    = ramAddr_i[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

`ifdef SRAM_LAST_WORD_BUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [19:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_word_q, buf_word_d;

  assign hit      = buf_valid_q && (buf_addr_q == ramAddr_i[21:2]);
  assign src_word = (state_q == S_IDLE) ? buf_word_q : sram_data_i;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_word_d  = buf_word_q;
    if (accept && in_store) begin
      buf_valid_d = 1'b0;
    end else if (load_done) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = (state_q == S_IDLE) ? ramAddr_i[21:2] : addr_q;
      buf_word_d  = src_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_word_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_word_q  <= buf_word_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign src_word = sram_data_i;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = in_load || in_store;
        if (in_load) begin
          state_d = hit ? S_DONE : S_READ;
        end else if (in_store) begin
          state_d = S_WSETUP;
        end
      end
      S_READ: begin
        stall_o = 1'b1;
        if (cnt_q == LAST_WAIT) state_d = S_DONE;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      S_WSETUP: begin
        stall_o = 1'b1;
        state_d = S_WPULSE;
      end
      S_WPULSE: begin
        stall_o = 1'b1;
        if (cnt_q == LAST_WAIT) state_d = S_WHOLD;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      S_WHOLD: begin
        stall_o = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rst) stall_o = 1'b0;
  end

  // SRAM pins are registered from the next state so they line up with the state they belong to.
  always_comb begin
    active_d  = (state_d == S_READ) || (state_d == S_WSETUP) ||
                (state_d == S_WPULSE) || (state_d == S_WHOLD);
    op_d      = accept ? ramOp_i : op_q;
    lo_d      = accept ? ramAddr_i[1:0] : lo_q;
    addr_d    = accept ? ramAddr_i[21:2] : addr_q;
    wdata_d   = (accept && in_store) ? wdata_new : wdata_q;
    be_n_d    = !active_d ? 4'b1111 : (accept ? be_new : be_n_q);
    ce_n_d    = !active_d;
    oe_n_d    = (state_d != S_READ);
    we_n_d    = (state_d != S_WPULSE);
    data_oe_d = active_d && (state_d != S_READ);
    load_done = (state_d == S_DONE) && ((state_q == S_READ) || (state_q == S_IDLE));
    src_op    = (state_q == S_IDLE) ? ramOp_i : op_q;
    src_lo    = (state_q == S_IDLE) ? ramAddr_i[1:0] : lo_q;
    load_data_d = load_done ? extract(src_op, src_lo, src_word) : load_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= `MEM_NOP;
      lo_q        <= '0;
      load_data_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_n_q      <= 4'b1111;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      load_data_q <= load_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_n_q      <= be_n_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign load_data_o    = load_data_q;
  assign sram_addr_o    = addr_q;
  assign sram_data_o    = wdata_q;
  assign sram_data_oe_o = data_oe_q;
  assign sram_be_n_o    = be_n_q;
  assign sram_ce_n_o    = ce_n_q;
  assign sram_oe_n_o    = oe_n_q;
  assign sram_we_n_o    = we_n_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: two controllers (1 and 3 wait states), each on its own SRAM model,
// checked against a word-array reference model of the load/store rules.
`default_nettype none

`ifndef MEM_NOP
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LBU 4'd2
`define MEM_LH  4'd3
`define MEM_LHU 4'd4
`define MEM_LW  4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

module tb_sram_mem_ctrl;

`ifdef SRAM_LAST_WORD_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  op_i   [2];
  logic [31:0] addr_i [2];
  logic [31:0] wd_i   [2];
  logic [31:0] ld_o   [2];
  logic        stall  [2];
  logic [19:0] sa     [2];
  logic [31:0] sdi    [2];
  logic [31:0] sdo    [2];
  logic        doe    [2];
  logic [3:0]  be     [2];
  logic        ce     [2];
  logic        oen    [2];
  logic        we     [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [31:0] mem [0:1023];

    sram_mem_ctrl #(.WAIT_CYCLES(k == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst(rst),
      .ramOp_i(op_i[k]), .ramAddr_i(addr_i[k]), .storeData_i(wd_i[k]),
      .load_data_o(ld_o[k]), .stall_o(stall[k]),
      .sram_addr_o(sa[k]), .sram_data_i(sdi[k]), .sram_data_o(sdo[k]),
      .sram_data_oe_o(doe[k]), .sram_be_n_o(be[k]),
      .sram_ce_n_o(ce[k]), .sram_oe_n_o(oen[k]), .sram_we_n_o(we[k])
    );

    assign sdi[k] = (!ce[k] && !oen[k]) ? mem[sa[k][9:0]] : 32'h0;

    always @(posedge clk) begin
      if (!ce[k] && !we[k]) begin
        for (int l = 0; l < 4; l++)
          if (!be[k][l]) mem[sa[k][9:0]][8*l +: 8] <= sdo[k][8*l +: 8];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word memory, last load value, last-word buffer.
  logic [31:0] rmem [2][0:1023];
  logic [31:0] last_ld [2];
  logic        mvalid [2];
  logic [19:0] maddr  [2];

  typedef struct {
    int          cycles;
    int          ce_low;
    int          we_low;
    logic [19:0] a2;
    logic [3:0]  be2;
    logic [31:0] d2;
    logic        oe2;
    logic [31:0] ld;
  } obs_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_ld;
    logic [3:0]  exp_be;
    logic [31:0] exp_d;
  } vec_t;

  function automatic int wv(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  function automatic logic is_st(input logic [3:0] op);
    return (op == `MEM_SB) || (op == `MEM_SH) || (op == `MEM_SW);
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((word >> (8 * int'(addr[1:0]))) & 32'hFF);
    h = 16'((word >> (16 * int'(addr[1]))) & 32'hFFFF);
    case (op)
      `MEM_LB:  return 32'($signed(b));
      `MEM_LBU: return 32'(b);
      `MEM_LH:  return 32'($signed(h));
      `MEM_LHU: return 32'(h);
      default:  return word;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_op(input int s, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] data, output obs_t o);
    o = '{default: 0};
    @(negedge clk);
    op_i[s] = op; addr_i[s] = addr; wd_i[s] = data;
    #1;
    o.cycles = 1;
    while (stall[s] && o.cycles < 40) begin
      @(negedge clk); #1;
      o.cycles++;
      if (!ce[s]) o.ce_low++;
      if (!we[s]) o.we_low++;
      if (o.cycles == 2) begin
        o.a2 = sa[s]; o.be2 = be[s]; o.d2 = sdo[s]; o.oe2 = doe[s];
      end
    end
    o.ld = ld_o[s];
    op_i[s] = `MEM_NOP; addr_i[s] = $urandom; wd_i[s] = $urandom;
  endtask

  task automatic run_op(input int s, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] data, output obs_t o);
    int          w, idx, ec, lane;
    logic        hit;
    logic [31:0] el, word, ed;
    logic [3:0]  eb;
    w   = wv(s);
    idx = int'(addr[11:2]);
    hit = BUF && !is_st(op) && mvalid[s] && (maddr[s] == addr[21:2]);
    ec  = is_st(op) ? w + 4 : (hit ? 2 : w + 2);
    do_op(s, op, addr, data, o);
    chk("cycles", 32'(o.cycles), 32'(ec));
    if (is_st(op)) begin
      word = rmem[s][idx];
      lane = int'(addr[1:0]);
      if (op == `MEM_SB) begin
        word[8*lane +: 8] = data[7:0];
        ed = data[7:0] * 32'h01010101;
        eb = ~(4'b0001 << lane);
      end else if (op == `MEM_SH) begin
        word[16*int'(addr[1]) +: 16] = data[15:0];
        ed = data[15:0] * 32'h00010001;
        eb = addr[1] ? 4'b0011 : 4'b1100;
      end else begin
        word = data; ed = data; eb = 4'b0000;
      end
      rmem[s][idx] = word;
      mvalid[s] = 1'b0;
      chk("store_addr", 32'(o.a2), 32'(addr[21:2]));
      chk("store_be_n", 32'(o.be2), 32'(eb));
      chk("store_data", o.d2, ed);
      chk("store_data_oe", 32'(o.oe2), 32'd1);
      chk("we_low_cycles", 32'(o.we_low), 32'(w));
      chk("ce_low_cycles", 32'(o.ce_low), 32'(w + 2));
      chk("load_data_held", o.ld, last_ld[s]);
    end else begin
      el = model_load(op, addr, rmem[s][idx]);
      chk("load_data", o.ld, el);
      last_ld[s] = el;
      mvalid[s]  = 1'b1;
      maddr[s]   = addr[21:2];
      if (hit) begin
        chk("hit_ce_low", 32'(o.ce_low), 32'd0);
      end else begin
        chk("load_addr", 32'(o.a2), 32'(addr[21:2]));
        chk("load_be_n", 32'(o.be2), 32'd0);
        chk("load_ce_low", 32'(o.ce_low), 32'(w));
        chk("load_we_low", 32'(o.we_low), 32'd0);
      end
    end
  endtask

  logic [3:0] ops [8];
  vec_t       tbl [8];

  initial begin
    obs_t        o;
    logic [3:0]  op;
    logic [31:0] addr;
    int          guard;

    for (int s = 0; s < 2; s++) begin
      op_i[s] = `MEM_LW; addr_i[s] = 32'h80000104; wd_i[s] = 32'h0;
      last_ld[s] = '0; mvalid[s] = 1'b0; maddr[s] = '0;
      for (int i = 0; i < 1024; i++) rmem[s][i] = '0;
    end
    ops = '{`MEM_LB, `MEM_LBU, `MEM_LH, `MEM_LHU, `MEM_LW, `MEM_SB, `MEM_SH, `MEM_SW};

    tbl[0] = '{`MEM_SW,  32'h80000104, 32'hDEADBEEF, 32'h00000000, 4'b0000, 32'hDEADBEEF};
    tbl[1] = '{`MEM_SB,  32'h80000106, 32'h000000A5, 32'h00000000, 4'b1011, 32'hA5A5A5A5};
    tbl[2] = '{`MEM_LW,  32'h80000104, 32'h0,        32'hDEA5BEEF, 4'b0000, 32'h0};
    tbl[3] = '{`MEM_SW,  32'h80000200, 32'h8001F0FF, 32'hDEA5BEEF, 4'b0000, 32'h8001F0FF};
    tbl[4] = '{`MEM_LB,  32'h80000200, 32'h0,        32'hFFFFFFFF, 4'b0000, 32'h0};
    tbl[5] = '{`MEM_LBU, 32'h80000201, 32'h0,        32'h000000F0, 4'b0000, 32'h0};
    tbl[6] = '{`MEM_LH,  32'h80000202, 32'h0,        32'hFFFF8001, 4'b0000, 32'h0};
    tbl[7] = '{`MEM_LHU, 32'h80000200, 32'h0,        32'h0000F0FF, 4'b0000, 32'h0};

    // Reset held with a load presented: everything must stay inactive.
    repeat (3) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_stall", 32'(stall[s]), 32'd0);
      chk("rst_be_n", 32'(be[s]), 32'hF);
      chk("rst_strobes", 32'({ce[s], oen[s], we[s], doe[s]}), 32'b1110);
      chk("rst_load_data", ld_o[s], 32'h0);
      chk("rst_sram_addr", 32'(sa[s]), 32'h0);
    end
    op_i[0] = `MEM_NOP; op_i[1] = `MEM_NOP;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(0, tbl[i].op, tbl[i].addr, tbl[i].data, o);
      chk("tbl_load_data", o.ld, tbl[i].exp_ld);
      if (is_st(tbl[i].op)) begin
        chk("tbl_be_n", 32'(o.be2), 32'(tbl[i].exp_be));
        chk("tbl_sram_data", o.d2, tbl[i].exp_d);
      end
    end

    // Randomized traffic on both wait-state settings over eight words.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++)
        run_op(s, `MEM_SW, 32'h80001000 + 32'(4 * i), $urandom, o);
      for (int n = 0; n < 60; n++) begin
        op   = ops[$urandom_range(0, 7)];
        addr = 32'h80001000 + 32'(4 * $urandom_range(0, 7));
        if (op == `MEM_LB || op == `MEM_LBU || op == `MEM_SB)
          addr[1:0] = 2'($urandom_range(0, 3));
        else if (op == `MEM_LH || op == `MEM_LHU || op == `MEM_SH)
          addr[1] = 1'($urandom_range(0, 1));
        run_op(s, op, addr, $urandom, o);
      end
    end

    // Reset during the write pulse of the slow controller aborts the access.
    @(negedge clk);
    op_i[1] = `MEM_SW; addr_i[1] = 32'h80003F00; wd_i[1] = 32'h12345678;
    #1;
    guard = 0;
    while (we[1] && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("abort_reached_wpulse", 32'(we[1]), 32'd0);
    rst = 1'b1;
    op_i[1] = `MEM_NOP;
    @(negedge clk); #1;
    chk("abort_we_n", 32'(we[1]), 32'd1);
    chk("abort_data_oe", 32'(doe[1]), 32'd0);
    chk("abort_ce_n", 32'(ce[1]), 32'd1);
    chk("abort_stall", 32'(stall[1]), 32'd0);
    chk("abort_load_data", ld_o[1], 32'h0);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      last_ld[s] = '0; mvalid[s] = 1'b0;
    end
    run_op(1, `MEM_LW, 32'h80001000, 32'h0, o);
    chk("post_abort_cycles", 32'(o.cycles), 32'd5);

    // Same-word load pairs around a store exercise the last-word buffer.
    run_op(0, `MEM_LW, 32'h80001008, 32'h0, o);
    run_op(0, `MEM_LW, 32'h80001008, 32'h0, o);
    chk("repeat_load_cycles", 32'(o.cycles), BUF ? 32'd2 : 32'd3);
    run_op(0, `MEM_SW, 32'h80001008, 32'hCAFEF00D, o);
    run_op(0, `MEM_LW, 32'h80001008, 32'h0, o);
    chk("load_after_store", o.ld, 32'hCAFEF00D);
    chk("load_after_store_cycles", 32'(o.cycles), 32'd3);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Memory-side responder for the pipeline's MEM-stage data port, bridging it to a single 32-bit asynchronous external SRAM.
- Accepts `ramOp`/`ramAddr`/`storeData` from MEM and runs a multi-cycle SRAM read or write with byte enables.
- Returns the sign- or zero-extended load result on `load_data`.
- Holds the pipeline with `stall_o` until the access completes.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: SRAM access wait states; legal range 1..15.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset; synchronous and active-high.
- `ramOp_i` in 4: operation code, one of the shared defines: `MEM_NOP`, `MEM_LB`, `MEM_LBU`, `MEM_LH`, `MEM_LHU`, `MEM_LW`, `MEM_SB`, `MEM_SH`, `MEM_SW`.
- `ramAddr_i` in 32: byte address.
- `storeData_i` in 32: store data, right-aligned.
- `load_data_o` out 32: extended load result; valid in the DONE cycle.
- `stall_o` out 1: holds the pipeline while an access is in flight.
- `sram_addr_o` out 20: word address, `ramAddr_i[21:2]`.
- `sram_data_i` in 32: SRAM read data.
- `sram_data_o` out 32: SRAM write data.
- `sram_data_oe_o` out 1: high while the block drives the SRAM data bus.
- `sram_be_n_o` out 4: byte enables, active-low; lane k covers bits `8k+7:8k`.
- `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o` out 1 each: SRAM strobes, active-low.

## Operation
FSM states and transitions:
- IDLE → READ: on a load op.
- IDLE → WSETUP: on a store op.
- READ → DONE: after `WAIT_CYCLES` cycles in READ.
- WSETUP → WPULSE (1 cycle).
- WPULSE → WHOLD: after `WAIT_CYCLES` cycles in WPULSE.
- WHOLD → DONE (1 cycle).
- DONE → IDLE (1 cycle).

Accept (IDLE, `ramOp_i != MEM_NOP`):
- Registers op, `addr[1:0]`, word address, lane-placed data and byte enables.
- `ramAddr_i`/`storeData_i` are not sampled after acceptance.

Address and alignment:
- Low address bits select lanes only; the SRAM address is always word-aligned.
- Misaligned LH/LHU/LW/SH/SW are not trapped (MEM already raises AdEL/AdES and forces NOP); the lane choice follows `addr[1]` for halfwords and ignores `addr[1:0]` for words.

Store lane placement:
- SB: byte replicated to all 4 lanes; `be_n = ~(4'b0001 << addr[1:0])`.
- SH: halfword in both halves; `be_n` = `1100` if `addr[1]==0`, else `0011`.
- SW: `be_n = 0000`.

Loads:
- `be_n = 0000`; the word is captured from `sram_data_i` on the last READ cycle.
- LB/LBU select byte `addr[1:0]`; LH/LHU select half `addr[1]`; LW passes the word.
- LB/LH sign-extend; LBU/LHU zero-extend.

Strobes per state:
- READ: ce_n=0, oe_n=0, we_n=1, data_oe=0.
- WSETUP and WHOLD: ce_n=0, oe_n=1, we_n=1, data_oe=1.
- WPULSE: ce_n=0, oe_n=1, we_n=0, data_oe=1.
- IDLE and DONE: ce_n=1, oe_n=1, we_n=1, data_oe=0, be_n=1111.
- All SRAM pins are registered.

`stall_o` (combinational):
- 1 in IDLE while `ramOp_i != MEM_NOP`.
- 1 in READ, WSETUP, WPULSE and WHOLD.
- 0 in DONE and in IDLE with NOP.

Outputs and reset:
- `load_data_o` updates only on entry to DONE and holds its value otherwise.
- Reset values: `load_data_o`=0, `sram_addr_o`=0, `sram_data_o`=0, `sram_data_oe_o`=0, `sram_be_n_o`=1111, all strobes 1, `stall_o`=0, state IDLE.
- `rst` asserted mid-access aborts the access: pins are inactive after the next edge; a write cut short may corrupt the addressed word.

## Timing
- Load: accept cycle T (stalled), READ T+1..T+W (stalled), DONE T+W+1 (`stall_o`=0, data valid). Total W+2 cycles.
- Store: accept T, WSETUP T+1, WPULSE T+2..T+W+1, WHOLD T+W+2, DONE T+W+3. Total W+4 cycles.
- Back-to-back: after DONE the pipeline advances, so the next op is seen in IDLE on the following cycle.
- No acceptance happens in DONE.
- Address and data are stable from WSETUP through WHOLD; `we_n` never falls in the same cycle as an address change.

## Configuration
- `SRAM_LAST_WORD_BUF_EN` defined:
  - A one-entry buffer holds {valid, word address, raw word}, written on every load DONE.
  - A load accepted in IDLE that hits (valid, address match) skips READ: accept T, DONE T+1, data from the buffer with the same lane extraction.
  - Any accepted store invalidates the buffer.
  - Reset clears valid.
- `SRAM_LAST_WORD_BUF_EN` undefined: no buffer; every load takes W+2 cycles.

## Test plan
- Reset with `ramOp_i=MEM_LW` held → `stall_o`=0, `be_n`=1111, strobes high, `load_data_o`=0.
- SW addr 0x80000104 data 0xDEADBEEF, W=1 → `sram_addr_o`=0x00041, `be_n`=0000, `we_n` low exactly 1 cycle, `stall_o` low on cycle 5 (DONE).
- SB addr 0x...0106 data 0x000000A5 → `sram_data_o`=0xA5A5A5A5, `be_n`=1011. Then LW at the same word returns 0xDEA5BEEF.
- SRAM word 0x8001F0FF: LB at `addr[1:0]`=0 → 0xFFFFFFFF; LBU at 1 → 0x000000F0; LH at 2 → 0xFFFF8001; LHU at 0 → 0x0000F0FF.
- W=3: LW → stalled 4 cycles, DONE on cycle 5. Assert `rst` during WPULSE → next cycle `we_n`=1, `data_oe`=0, state IDLE.
- `SRAM_LAST_WORD_BUF_EN`: LW A then LW A → second completes in 2 cycles with no ce_n pulse. Then SW A, LW A → full W+2 read.
